// File: rtl/nn_input_loader.sv
// nn_input_loader: assembles N streamed features into a vector and issues it to
// the inference pipeline with a one-cycle start pulse, checking frame alignment.
module nn_input_loader #(
    parameter int WIDTH     = 16,
    parameter int N         = 16,
    parameter int WAIT_DONE = 1,
    parameter int ERRW      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic signed [WIDTH-1:0]        s_data,
    input  logic                           s_last,
    output logic signed [N-1:0][WIDTH-1:0] vec_data,
    output logic                           vec_start,
    input  logic                           net_done,
    output logic                           busy,
    output logic                           frame_err,
    output logic [ERRW-1:0]                err_count
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [CW-1:0]           cnt;
    logic                    full;
    logic                    drop;
    logic                    inflight;
    logic [N-1:0][WIDTH-1:0] fill_buf;
    logic                    accept;
    logic                    at_last;
    logic                    issue;

    assign s_ready = !full;
    assign busy    = inflight;
    assign accept  = s_valid && !full;
    assign at_last = (cnt == LAST_IDX);
    // net_done frees the slot on the same edge it arrives, giving a zero-bubble hand-off
    assign issue   = full && ((WAIT_DONE == 0) || !inflight || net_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            full      <= 1'b0;
            drop      <= 1'b0;
            inflight  <= 1'b0;
            vec_start <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
            vec_data  <= '0;
            fill_buf  <= '0;
        end else begin
            frame_err <= 1'b0;
            vec_start <= issue;
            if (issue) begin
                vec_data <= fill_buf;
                full     <= 1'b0;
                inflight <= (WAIT_DONE != 0);
            end else if (net_done) begin
                inflight <= 1'b0;
            end

            if (accept) begin
                if (drop) begin
                    if (s_last) drop <= 1'b0;
                end else if (!at_last && !s_last) begin
                    fill_buf[cnt] <= s_data;
                    cnt           <= cnt + 1'b1;
                end else if (at_last && s_last) begin
                    fill_buf[cnt] <= s_data;
                    full          <= 1'b1;
                    cnt           <= '0;
                end else begin
                    // early last discards the partial; missing last also skips to the next last
                    frame_err <= 1'b1;
                    cnt       <= '0;
                    drop      <= at_last;
                    if (err_count != '1) err_count <= err_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nn_input_loader.sv
// Bench for nn_input_loader: two instances (throttled with ERRW=8, free-running with ERRW=2),
// frame-level reference model feeding a scoreboard that a negedge monitor drains.
module tb_nn_input_loader;
    localparam int N = 16;
    localparam int W = 16;
    typedef logic [N-1:0][W-1:0] vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid [2];
    logic         s_last [2];
    logic         net_done [2];
    logic [W-1:0] s_data [2];
    logic         s_ready [2];
    logic         vec_start [2];
    logic         busy [2];
    logic         frame_err [2];
    vec_t         vec_data [2];
    logic [1:0]   ec0;
    logic [7:0]   ec1;

    logic [W-1:0] frame_q [2][$];
    bit           drop_m [2];
    vec_t         exp_q [2][$];
    int           err_m [2];
    int           obs_err [2];
    int           n_cmp = 0;
    int           n_bad = 0;
    longint       cyc = 0;
    longint       start_t0 [$];
    bit           busy0_ever = 0;
    bit           stop_pulser;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nn_input_loader #(.WIDTH(W), .N(N), .WAIT_DONE(0), .ERRW(2)) dut0 (
        .clk(clk), .reset(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .s_last(s_last[0]), .vec_data(vec_data[0]),
        .vec_start(vec_start[0]), .net_done(net_done[0]), .busy(busy[0]),
        .frame_err(frame_err[0]), .err_count(ec0));

    nn_input_loader #(.WIDTH(W), .N(N), .WAIT_DONE(1), .ERRW(8)) dut1 (
        .clk(clk), .reset(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .s_last(s_last[1]), .vec_data(vec_data[1]),
        .vec_start(vec_start[1]), .net_done(net_done[1]), .busy(busy[1]),
        .frame_err(frame_err[1]), .err_count(ec1));

    function automatic logic [7:0] ec(int k);
        return (k == 1) ? ec1 : {6'b0, ec0};
    endfunction

    function automatic int exp_ec(int k);
        int mx = (k == 1) ? 255 : 3;
        return (err_m[k] > mx) ? mx : err_m[k];
    endfunction

    // Frame-level rules: a frame is good only if s_last lands exactly on word N.
    function automatic void model_accept(int k, logic [W-1:0] d, bit last);
        vec_t v;
        if (drop_m[k]) begin
            if (last) drop_m[k] = 0;
            return;
        end
        frame_q[k].push_back(d);
        if (last) begin
            if (frame_q[k].size() == N) begin
                for (int i = 0; i < N; i++) v[i] = frame_q[k][i];
                exp_q[k].push_back(v);
            end else begin
                err_m[k]++;
            end
            frame_q[k].delete();
        end else if (frame_q[k].size() == N) begin
            err_m[k]++;
            frame_q[k].delete();
            drop_m[k] = 1;
        end
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(int k, logic [W-1:0] d, bit last);
        int t = 0;
        s_valid[k] = 1; s_data[k] = d; s_last[k] = last;
        while (!s_ready[k] && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL s_ready_timeout dut%0d: got 0 expected 1", k);
            s_valid[k] = 0;
            return;
        end
        @(posedge clk);
        model_accept(k, d, last);
        @(negedge clk);
    endtask

    task automatic idle(int k);
        s_valid[k] = 0; s_last[k] = 0;
    endtask

    task automatic send_frame(int k, int base);
        for (int i = 0; i < N; i++) send(k, W'(base + i), i == N - 1);
        idle(k);
    endtask

    task automatic drain(int k);
        int t = 0;
        if (k == 1) net_done[1] = 1;
        while (exp_q[k].size() != 0 && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", k, exp_q[k].size());
        end
        @(negedge clk);
        net_done[1] = 0;
        if (k == 1) chk("busy_after_done", busy[1], 0);
    endtask

    task automatic rand_frames(int k, int nf);
        int r, len;
        for (int f = 0; f < nf; f++) begin
            r = $urandom % 10;
            if (r < 6)      len = N;
            else if (r < 8) len = 1 + ($urandom % (N - 1));
            else            len = N + 1 + ($urandom % 3);
            for (int i = 0; i < len; i++) begin
                send(k, W'($urandom), i == len - 1);
                if ($urandom % 4 == 0) begin
                    idle(k);
                    repeat (1 + $urandom % 3) @(negedge clk);
                end
            end
            idle(k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            idle(k); net_done[k] = 0;
            frame_q[k].delete(); exp_q[k].delete();
            drop_m[k] = 0; err_m[k] = 0; obs_err[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        vec_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst_n && vec_start[k]) begin
                if (exp_q[k].size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_start dut%0d: got start expected none", k);
                end else begin
                    e = exp_q[k].pop_front();
                    n_cmp++;
                    if (vec_data[k] !== e) begin
                        n_bad++;
                        $display("FAIL vec_data dut%0d: got %h expected %h", k, vec_data[k], e);
                    end
                end
                if (k == 0) start_t0.push_back(cyc);
            end
            if (rst_n && frame_err[k]) obs_err[k]++;
        end
        if (rst_n && busy[0]) busy0_ever = 1;
    end

    initial begin
        bit   saw;
        int   t;
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 0; s_last[k] = 0; s_data[k] = '0; net_done[k] = 0;
        end
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_s_ready", s_ready[k], 1);
            chk("rst_vec_start", vec_start[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_err_count", ec(k), 0);
            chk("rst_vec_data_zero", vec_data[k] == '0, 1);
        end

        // frame 1..16 issues one cycle after the last accept and stays in flight
        for (int i = 1; i <= N; i++) send(1, W'(i), i == N);
        idle(1);
        chk("t1_start_not_yet", vec_start[1], 0);
        @(negedge clk);
        chk("t1_start", vec_start[1], 1);
        chk("t1_busy", busy[1], 1);
        chk("t1_elem0", vec_data[1][0], 1);
        chk("t1_elem15", vec_data[1][N-1], 16);
        @(negedge clk);
        chk("t1_start_one_cycle", vec_start[1], 0);
        chk("t1_busy_held", busy[1], 1);

        // second vector waits for net_done, then issues on that edge
        for (int i = 0; i < N; i++) send(1, W'(101 + i), i == N - 1);
        idle(1);
        chk("t2_backpressure", s_ready[1], 0);
        saw = 0;
        repeat (3) begin @(negedge clk); if (vec_start[1]) saw = 1; end
        chk("t2_no_start_while_busy", saw, 0);
        net_done[1] = 1;
        @(negedge clk);
        net_done[1] = 0;
        chk("t2_start_on_done", vec_start[1], 1);
        chk("t2_busy_handoff", busy[1], 1);
        @(negedge clk);
        chk("t2_s_ready_back", s_ready[1], 1);
        drain(1);

        // early last
        for (int i = 0; i < 5; i++) send(1, W'(51 + i), i == 4);
        idle(1);
        chk("t3_frame_err", frame_err[1], 1);
        chk("t3_err_count", ec(1), 1);
        send_frame(1, 201);
        drain(1);

        // missing last: error on word 16, word 17 swallowed
        for (int i = 0; i < N; i++) send(1, W'(301 + i), 0);
        chk("t4_frame_err", frame_err[1], 1);
        chk("t4_err_count", ec(1), 2);
        send(1, W'(317), 1);
        idle(1);
        send_frame(1, 401);
        drain(1);

        // unthrottled instance: back-to-back frames 17 cycles apart
        start_t0.delete();
        for (int i = 0; i < 2 * N; i++) send(0, W'(601 + i), (i % N) == N - 1);
        idle(0);
        t = 0;
        while (start_t0.size() < 2 && t < 100) begin @(negedge clk); t++; end
        if (start_t0.size() < 2) begin
            n_cmp++; n_bad++;
            $display("FAIL t5_starts: got %0d expected 2", start_t0.size());
        end else begin
            chk("t5_spacing", start_t0[1] - start_t0[0], 17);
        end
        drain(0);

        // randomized traffic on both instances
        stop_pulser = 0;
        fork
            begin rand_frames(1, 40); stop_pulser = 1; end
            begin
                while (!stop_pulser) begin
                    @(negedge clk);
                    net_done[1] = ($urandom % 5 == 0);
                end
                net_done[1] = 0;
            end
        join
        drain(1);
        rand_frames(0, 40);
        drain(0);
        for (int k = 0; k < 2; k++) begin
            chk("rand_err_count", ec(k), exp_ec(k));
            chk("rand_err_pulses", obs_err[k], err_m[k]);
        end
        chk("busy_never_unthrottled", busy0_ever, 0);

        // reset mid-frame
        for (int i = 0; i < 9; i++) send(1, W'(701 + i), 0);
        do_reset();
        @(negedge clk);
        chk("t6_s_ready", s_ready[1], 1);
        chk("t6_err_count", ec(1), 0);
        chk("t6_busy", busy[1], 0);
        send_frame(1, 501);
        drain(1);
        for (int k = 0; k < 2; k++) begin
            chk("final_pending", exp_q[k].size(), 0);
            chk("final_err_pulses", obs_err[k], err_m[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
